keyboard_key_latch: RTL

- Keyboard-side producer of the six memory-mapped key registers (W, S, D, A, Space, Esc) that the memory controller returns on CPU loads.
- Consumes PS/2 scan-code set 2 bytes from the PS/2 byte receiver and decodes make, break and extended sequences.
- Keeps a held flag and a sticky pressed flag per key; the controller's Keyboard_reset pulse clears the sticky flags.
- Sits between the PS/2 receiver and the memory controller's FORWARD_In…RESET_In inputs.

---
 rtl/keyboard_key_latch_pkg.sv | 8 +
 rtl/keyboard_key_latch_if.sv | 8 +
 rtl/keyboard_key_latch_scan_code_map.sv | 15 +
 rtl/keyboard_key_latch.sv | 62 ++++++
 4 files changed

// File: rtl/keyboard_key_latch_pkg.sv
// keyboard_key_latch_pkg: scan codes, key indices and decoder states shared by the key latch
package keyboard_key_latch_pkg;
  localparam logic [7:0] CW = 8'h1D, CS = 8'h1B, CD = 8'h23, CA = 8'h1C;
  localparam logic [7:0] CSP = 8'h29, CESC = 8'h76, CF0 = 8'hF0, CE0 = 8'hE0;
  localparam logic [2:0] KEY_W = 3'd0, KEY_S = 3'd1, KEY_D = 3'd2;
  localparam logic [2:0] KEY_A = 3'd3, KEY_SP = 3'd4, KEY_ESC = 3'd5;
  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
endpackage

// File: rtl/keyboard_key_latch_if.sv
// keyboard_key_latch_if: byte stream from the PS/2 receiver
interface keyboard_key_latch_if;
  logic [7:0] scan_code;
  logic scan_valid;
  logic scan_err;
  modport master(output scan_code, scan_valid, scan_err);
  modport slave(input scan_code, scan_valid, scan_err);
endinterface

// File: rtl/keyboard_key_latch_scan_code_map.sv
// scan_code_map: maps a set-2 scan code to one of the six tracked keys
module scan_code_map
  import keyboard_key_latch_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit,
  output logic [2:0] key
);
  assign {hit, key} = code == CW   ? {1'b1, KEY_W}   :
                      code == CS   ? {1'b1, KEY_S}   :
                      code == CD   ? {1'b1, KEY_D}   :
                      code == CA   ? {1'b1, KEY_A}   :
                      code == CSP  ? {1'b1, KEY_SP}  :
                      code == CESC ? {1'b1, KEY_ESC} : 4'b0;
endmodule

// File: rtl/keyboard_key_latch.sv
// keyboard_key_latch: decodes PS/2 make/break/extended sequences into held and sticky key flags
module keyboard_key_latch
  import keyboard_key_latch_pkg::*;
#(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset,
  keyboard_key_latch_if.slave  sc,
  input  logic                 Keyboard_reset,
  output logic [15:0]          FORWARD_Out,
  output logic [15:0]          BACKWARD_Out,
  output logic [15:0]          TURNRIGHT_Out,
  output logic [15:0]          TURNLEFT_Out,
  output logic [15:0]          SHOOT_Out,
  output logic [15:0]          RESET_Out,
  output logic [5:0]           held
);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [5:0] latched, held_n, latched_n, onehot;
  logic [2:0] key;
  logic hit, live, mk, bk, tmo;
  scan_code_map u_map (.code(sc.scan_code), .hit(hit), .key(key));
  always_comb begin
    live = sc.scan_valid && !sc.scan_err;
    mk = live && state == IDLE && hit;
    bk = live && state == BREAK && hit;
    onehot = 6'b1 << key;
    held_n = mk ? held | onehot : bk ? held & ~onehot : held;
    // clear uses the post-event held value so a same-cycle make survives and a break clears
    latched_n = Keyboard_reset ? held_n : mk ? latched | onehot : latched;
    tmo = state != IDLE && cnt == PREFIX_TIMEOUT - 16'd1;
    state_n = state;
    if (sc.scan_err || (!sc.scan_valid && tmo))
      state_n = IDLE;
    else if (sc.scan_valid)
      state_n = (state == IDLE && sc.scan_code == CF0) ? BREAK :
                (state == IDLE && sc.scan_code == CE0) ? EXT :
                (state == EXT && sc.scan_code == CF0)  ? EXT_BREAK : IDLE;
    cnt_n = (sc.scan_valid || state == IDLE || tmo) ? 16'd0 : cnt + {15'd0, cnt != 16'hFFFF};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      held <= '0;
      latched <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      held <= held_n;
      latched <= latched_n;
    end
  end
  assign FORWARD_Out   = {15'b0, latched[KEY_W]};
  assign BACKWARD_Out  = {15'b0, latched[KEY_S]};
  assign TURNRIGHT_Out = {15'b0, latched[KEY_D]};
  assign TURNLEFT_Out  = {15'b0, latched[KEY_A]};
  assign SHOOT_Out     = {15'b0, latched[KEY_SP]};
  assign RESET_Out     = {15'b0, latched[KEY_ESC]};
endmodule
